// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: execute stage with single-cycle ALU, iterative 32-cycle mul/div unit
// driving HI/LO, and the EX/MEM pipeline register.
module ex_muldiv_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic        RegWrite_in,
   input  logic        MemtoReg_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        RegDst_in,
   input  logic        ALUsrc_in,
   input  logic [4:0]  ALUop_in,
   input  logic [31:0] data_1_in,
   input  logic [31:0] data_2_in,
   input  logic [31:0] imm_in,
   input  logic [4:0]  RD_in,
   input  logic [4:0]  RT_in,
   input  logic [4:0]  shamt_in,
   output logic        RegWrite_out,
   output logic        MemtoReg_out,
   output logic        MemRead_out,
   output logic        MemWrite_out,
   output logic [31:0] alu_result,
   output logic [31:0] store_data,
   output logic [4:0]  dest_reg,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] b_q, b_d, dvd_q, dvd_d, hi_q, hi_d, lo_q, lo_d;
   logic        is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
   logic        rw_q, rw_d, m2r_q, m2r_d, mr_q, mr_d, mw_q, mw_d;
   logic [31:0] alu_q, alu_d, st_q, st_d;
   logic [4:0]  dst_q, dst_d;
   logic [31:0] op_b, alu, a_mag, b_mag, div_sub, quo, rem, fin_hi, fin_lo;
   logic [32:0] mul_sum, div_t;
   logic [63:0] step, prod;
   logic        md_op, a_neg, b_neg, start, last, done, div_ge;
   always_comb begin
      op_b = ALUsrc_in ? imm_in : data_2_in;
      alu  = '0;
      case (ALUop_in)
         5'd0:  alu = data_1_in + op_b;
         5'd1:  alu = data_1_in - op_b;
         5'd2:  alu = data_1_in & op_b;
         5'd3:  alu = data_1_in | op_b;
         5'd4:  alu = data_1_in ^ op_b;
         5'd5:  alu = ~(data_1_in | op_b);
         5'd6:  alu = {31'd0, $signed(data_1_in) < $signed(op_b)};
         5'd7:  alu = {31'd0, data_1_in < op_b};
         5'd8:  alu = op_b << shamt_in;
         5'd9:  alu = op_b >> shamt_in;
         5'd10: alu = $signed(op_b) >>> shamt_in;
         5'd11: alu = op_b << 16;
         5'd20: alu = hi_q;
         5'd21: alu = lo_q;
         default: alu = '0;
      endcase
   end
   // Operands are iterated as magnitudes; signs are reapplied when the result is written.
   always_comb begin
      md_op   = ALUop_in[4:2] == 3'b100;
      a_neg   = ~ALUop_in[0] & data_1_in[31];
      b_neg   = ~ALUop_in[0] & op_b[31];
      a_mag   = a_neg ? -data_1_in : data_1_in;
      b_mag   = b_neg ? -op_b : op_b;
      mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
      div_t   = acc_q[63:31];
      div_ge  = div_t >= {1'b0, b_q};
      div_sub = div_t[31:0] - b_q;
      step    = is_div_q ? (div_ge ? {div_sub, acc_q[30:0], 1'b1} : {div_t[31:0], acc_q[30:0], 1'b0})
                         : {mul_sum, acc_q[31:1]};
      prod    = neg_q ? -step : step;
      quo     = neg_q ? -step[31:0] : step[31:0];
      rem     = rneg_q ? -step[63:32] : step[63:32];
      fin_hi  = is_div_q ? (b_q == '0 ? dvd_q : rem) : prod[63:32];
      fin_lo  = is_div_q ? (b_q == '0 ? '1 : quo) : prod[31:0];
   end
   always_comb begin
      start    = state_q == IDLE && md_op;
      last     = state_q == RUN && count_q == 5'd31;
      done     = state_q == DONE;
      busy     = start || state_q == RUN;
      state_d  = start ? RUN : last ? DONE : state_q == RUN ? RUN : IDLE;
      count_d  = state_q == RUN ? count_q + 5'd1 : 5'd0;
      acc_d    = start ? {32'd0, a_mag} : state_q == RUN ? step : acc_q;
      b_d      = start ? b_mag : b_q;
      dvd_d    = start ? data_1_in : dvd_q;
      is_div_d = start ? ALUop_in[1] : is_div_q;
      neg_d    = start ? a_neg ^ b_neg : neg_q;
      rneg_d   = start ? a_neg : rneg_q;
      hi_d     = last ? fin_hi : hi_q;
      lo_d     = last ? fin_lo : lo_q;
      rw_d     = ~busy & ~done & RegWrite_in;
      m2r_d    = ~busy & MemtoReg_in;
      mr_d     = ~busy & MemRead_in;
      mw_d     = ~busy & MemWrite_in;
      alu_d    = (busy || done) ? '0 : alu;
      st_d     = data_2_in;
      dst_d    = RegDst_in ? RD_in : RT_in;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         dvd_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         rw_q     <= 1'b0;
         m2r_q    <= 1'b0;
         mr_q     <= 1'b0;
         mw_q     <= 1'b0;
         alu_q    <= '0;
         st_q     <= '0;
         dst_q    <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         dvd_q    <= dvd_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         rw_q     <= rw_d;
         m2r_q    <= m2r_d;
         mr_q     <= mr_d;
         mw_q     <= mw_d;
         alu_q    <= alu_d;
         st_q     <= st_d;
         dst_q    <= dst_d;
      end
   end
   assign RegWrite_out = rw_q;
   assign MemtoReg_out = m2r_q;
   assign MemRead_out  = mr_q;
   assign MemWrite_out = mw_q;
   assign alu_result   = alu_q;
   assign store_data   = st_q;
   assign dest_reg     = dst_q;
   assign hi           = hi_q;
   assign lo           = lo_q;
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb_ex_muldiv_stage: scoreboard bench; stimulus queues hand-computed EX/MEM results,
// a monitor checks every captured instruction, bubbles, stall length and reset state.
module tb_ex_muldiv_stage;
   logic        clock, reset;
   logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALUsrc_in;
   logic [4:0]  ALUop_in, RD_in, RT_in, shamt_in;
   logic [31:0] data_1_in, data_2_in, imm_in;
   logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, busy;
   logic [31:0] alu_result, store_data, hi, lo;
   logic [4:0]  dest_reg;

   typedef struct packed {
      logic [3:0]  ctl;
      logic [31:0] alu;
      logic [31:0] st;
      logic [4:0]  dst;
      logic [31:0] h;
      logic [31:0] l;
   } exp_t;

   exp_t        sb[$];
   int          tot, bad, run_len;
   logic        iss, mon_b, mon_r, mon_i;
   logic [31:0] m_hi, m_lo;
   exp_t        got, e;

   ex_muldiv_stage dut (
      .clock(clock), .reset(reset),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
      .MemWrite_in(MemWrite_in), .RegDst_in(RegDst_in), .ALUsrc_in(ALUsrc_in),
      .ALUop_in(ALUop_in), .data_1_in(data_1_in), .data_2_in(data_2_in), .imm_in(imm_in),
      .RD_in(RD_in), .RT_in(RT_in), .shamt_in(shamt_in),
      .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .MemRead_out(MemRead_out),
      .MemWrite_out(MemWrite_out), .alu_result(alu_result), .store_data(store_data),
      .dest_reg(dest_reg), .hi(hi), .lo(lo), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      mon_b = busy;
      mon_r = reset;
      mon_i = iss;
      #1;
      got = {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, alu_result, store_data, dest_reg, hi, lo};
      if (mon_r) begin
         run_len = 0;
         tot++;
         if ({got, busy} != '0) begin
            bad++;
            $display("FAIL reset got=%h busy=%b exp=0 busy=0", got, busy);
         end
      end else if (mon_b) begin
         run_len++;
         tot++;
         if ({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out} != 4'b0) begin
            bad++;
            $display("FAIL bubble got=%b exp=0000", {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out});
         end
      end else begin
         if (run_len != 0) begin
            tot++;
            if (run_len != 33) begin
               bad++;
               $display("FAIL busy_len got=%0d exp=33", run_len);
            end
            run_len = 0;
         end
         if (mon_i) begin
            tot++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL exmem got=%h exp=none", got);
            end else begin
               e = sb.pop_front();
               if (got != e) begin
                  bad++;
                  $display("FAIL exmem got=%h exp=%h", got, e);
               end
            end
         end
      end
   end

   task automatic run(input logic [4:0] op, input logic [3:0] ctl, input logic [31:0] a, d2, im,
                      input logic src, dsel, input logic [4:0] sh, input logic [31:0] e_alu, e_hi, e_lo);
      int   n;
      logic md;
      exp_t x;
      md = op[4:2] == 3'b100;
      @(negedge clock);
      ALUop_in = op;
      {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in} = ctl;
      data_1_in = a;
      data_2_in = d2;
      imm_in = im;
      ALUsrc_in = src;
      RegDst_in = dsel;
      shamt_in = sh;
      iss = 1'b1;
      if (md) begin
         m_hi = e_hi;
         m_lo = e_lo;
      end
      x.ctl = md ? {1'b0, ctl[2:0]} : ctl;
      x.alu = e_alu;
      x.st  = d2;
      x.dst = dsel ? RD_in : RT_in;
      x.h   = m_hi;
      x.l   = m_lo;
      sb.push_back(x);
      if (md) begin
         n = 0;
         #1;
         while (busy && n < 100) begin
            n++;
            @(negedge clock);
         end
         if (n >= 100) begin
            $display("FAIL stall_timeout got=%0d exp=33", n);
            $fatal(1, "stall did not end");
         end
      end
      @(posedge clock);
   endtask

   initial begin
      tot = 0; bad = 0; run_len = 0;
      m_hi = '0; m_lo = '0;
      iss = 1'b0; reset = 1'b1;
      {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALUsrc_in} = '0;
      ALUop_in = '0; data_1_in = '0; data_2_in = '0; imm_in = '0;
      RD_in = 5'd5; RT_in = 5'd9; shamt_in = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      run(5'd0,  4'b1000, 32'h7FFFFFFF, 32'h1,        32'h0,    0, 1, 0,  32'h80000000, 0, 0);
      run(5'd1,  4'b1100, 32'h5,        32'h7,        32'h0,    0, 0, 0,  32'hFFFFFFFE, 0, 0);
      run(5'd2,  4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,    0, 1, 0,  32'h00F000F0, 0, 0);
      run(5'd3,  4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,    0, 0, 0,  32'hFFF0FFF0, 0, 0);
      run(5'd4,  4'b1010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,    0, 1, 0,  32'hFF00FF00, 0, 0);
      run(5'd5,  4'b1000, 32'h0,        32'h0,        32'h0,    0, 0, 0,  32'hFFFFFFFF, 0, 0);
      run(5'd6,  4'b1000, 32'hFFFFFFFF, 32'h1,        32'h0,    0, 1, 0,  32'h1,        0, 0);
      run(5'd7,  4'b1000, 32'h1,        32'hFFFFFFFF, 32'h0,    0, 1, 0,  32'h1,        0, 0);
      run(5'd8,  4'b1000, 32'h0,        32'h1,        32'h0,    0, 1, 31, 32'h80000000, 0, 0);
      run(5'd9,  4'b1000, 32'h0,        32'h80000000, 32'h0,    0, 1, 4,  32'h08000000, 0, 0);
      run(5'd10, 4'b1000, 32'h0,        32'h80000000, 32'h0,    0, 1, 4,  32'hF8000000, 0, 0);
      run(5'd11, 4'b1000, 32'h0,        32'h0000AAAA, 32'h1234, 1, 0, 0,  32'h12340000, 0, 0);
      run(5'd12, 4'b1000, 32'h5,        32'h6,        32'h0,    0, 1, 0,  32'h0,        0, 0);
      run(5'd16, 4'b1000, 32'hFFFFFFFD, 32'h7,        32'h0,    0, 1, 0,  32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run(5'd21, 4'b1000, 32'h0,        32'h0,        32'h0,    0, 1, 0,  32'hFFFFFFEB, 0, 0);
      run(5'd20, 4'b1000, 32'h0,        32'h0,        32'h0,    0, 1, 0,  32'hFFFFFFFF, 0, 0);
      run(5'd18, 4'b1010, 32'hFFFFFFF9, 32'h2,        32'h0,    0, 0, 0,  32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run(5'd21, 4'b1000, 32'h0,        32'h0,        32'h0,    0, 1, 0,  32'hFFFFFFFD, 0, 0);
      run(5'd19, 4'b1000, 32'h7,        32'h0,        32'h0,    0, 1, 0,  32'h0, 32'h7, 32'hFFFFFFFF);
      run(5'd20, 4'b1000, 32'h0,        32'h0,        32'h0,    0, 1, 0,  32'h7,        0, 0);
      run(5'd18, 4'b1000, 32'h80000000, 32'hFFFFFFFF, 32'h0,    0, 1, 0,  32'h0, 32'h0, 32'h80000000);
      run(5'd19, 4'b1000, 32'd100,      32'd7,        32'h0,    0, 1, 0,  32'h0, 32'h2, 32'hE);
      run(5'd17, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,    0, 1, 0,  32'h0, 32'hFFFFFFFE, 32'h1);
      run(5'd16, 4'b1000, 32'h80000000, 32'h80000000, 32'h0,    0, 1, 0,  32'h0, 32'h40000000, 32'h0);
      // Cancel a MULTU with reset once the iteration count reaches 10.
      @(negedge clock);
      iss = 1'b0;
      ALUop_in = 5'd17;
      data_1_in = 32'hFFFFFFFF;
      data_2_in = 32'hFFFFFFFF;
      repeat (11) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      ALUop_in = 5'd0;
      @(negedge clock);
      reset = 1'b0;
      m_hi = '0;
      m_lo = '0;
      run(5'd0,  4'b1000, 32'h2,        32'h3,        32'h0,    0, 1, 0,  32'h5,        0, 0);
      run(5'd20, 4'b1000, 32'h0,        32'h0,        32'h0,    0, 1, 0,  32'h0,        0, 0);
      @(negedge clock);
      iss = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end
endmodule
